// File: rtl/rsa_operand_loader_pkg.sv
// rsa_operand_loader_pkg: shared widths and loader FSM states.
package rsa_operand_loader_pkg;
    localparam int RSA_WIDTH  = 4096;
    localparam int DATA_WIDTH = 64;
    localparam int RSA_WORDS  = RSA_WIDTH / DATA_WIDTH;
    localparam int CNT_W      = 7;
    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT} state_t;
endpackage

// File: rtl/rsa_operand_loader_word_assembler.sv
// rsa_word_assembler: collects one operand word by word and flags completion or framing errors.
module rsa_word_assembler
    import rsa_operand_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  last,
    input  logic                  clr,
    output logic [RSA_WIDTH-1:0]  value,
    output logic                  loaded,
    output logic                  err_pulse
);
    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end    = cnt == CNT_W'(RSA_WORDS - 1);
    // A complete operand is write-protected; a misplaced last marker drops the partial operand.
    assign err_pulse = wr_en & (loaded | (last ^ at_end));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value  <= '0;
            cnt    <= '0;
            loaded <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            loaded <= 1'b0;
        end else if (wr_en & ~loaded) begin
            if (last ^ at_end) begin
                cnt <= '0;
            end else begin
                value[cnt*DATA_WIDTH +: DATA_WIDTH] <= data;
                cnt    <= last ? '0 : cnt + 1'b1;
                loaded <= last;
            end
        end
    end
endmodule

// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader: assembles message/exponent/modulus and sequences one rsa4k operation.
module rsa_operand_loader
    import rsa_operand_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_last,
    input  logic                  keep_key,
    input  logic                  err_clr,
    output logic [RSA_WIDTH-1:0]  message,
    output logic [RSA_WIDTH-1:0]  exponent,
    output logic [RSA_WIDTH-1:0]  modulus,
    output logic                  rsa_go,
    input  logic                  rsa_done,
    output logic [2:0]            loaded,
    output logic                  busy,
    output logic                  op_done,
    output logic                  err
);
    state_t               state, state_nx;
    logic                 done_q, xfer, err_set;
    logic [2:0]           wr, clr, ep;
    logic [RSA_WIDTH-1:0] vals [3];

    assign xfer     = in_valid & in_ready;
    assign err_set  = xfer & ((in_sel == 2'd3) | (|ep));
    assign message  = vals[0];
    assign exponent = vals[1];
    assign modulus  = vals[2];

    for (genvar i = 0; i < 3; i++) begin : g_asm
        assign wr[i]  = xfer & (in_sel == 2'(i));
        assign clr[i] = op_done & ((i == 0) | ~keep_key);
        rsa_word_assembler u_asm (
            .clk(clk), .reset(reset), .wr_en(wr[i]), .data(in_data), .last(in_last),
            .clr(clr[i]), .value(vals[i]), .loaded(loaded[i]), .err_pulse(ep[i])
        );
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        rsa_go   = 1'b0;
        busy     = 1'b0;
        op_done  = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                state_nx = (&loaded) ? S_START : S_LOAD;
            end
            S_START: begin
                rsa_go   = 1'b1;
                busy     = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                op_done  = rsa_done & ~done_q;
                busy     = ~op_done;
                state_nx = op_done ? S_LOAD : S_WAIT;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_LOAD;
            done_q <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= (state == S_START) ? 1'b0 : rsa_done;
            err    <= err_set | (err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_rsa_operand_loader.sv
// tb_rsa_operand_loader: randomized word streams checked against a word-array operand model.
module tb_rsa_operand_loader;
    logic         clk = 1'b0, reset = 1'b1;
    logic         in_valid = 1'b0, in_last = 1'b0, keep_key = 1'b0, err_clr = 1'b0, rsa_done = 1'b0;
    logic [63:0]  in_data = '0;
    logic [1:0]   in_sel = '0;
    logic         in_ready, rsa_go, busy, op_done, err;
    logic [2:0]   loaded;
    logic [4095:0] message, exponent, modulus;

    int n_err = 0, n_chk = 0, go_cnt = 0, done_cnt = 0;

    logic [63:0] m_w [3][64];
    int          m_cnt [3];
    logic [2:0]  m_ld;
    logic        m_err;

    rsa_operand_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last), .keep_key(keep_key), .err_clr(err_clr),
        .message(message), .exponent(exponent), .modulus(modulus), .rsa_go(rsa_go),
        .rsa_done(rsa_done), .loaded(loaded), .busy(busy), .op_done(op_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rsa_go) go_cnt++;
        if (op_done) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [4095:0] got, input logic [4095:0] exp);
        n_chk++;
        if (got !== exp) begin
            int w = 0;
            for (int k = 63; k >= 0; k--) if (got[k*64 +: 64] !== exp[k*64 +: 64]) w = k;
            n_err++;
            $display("FAIL %s word%0d got=%h exp=%h", tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    function automatic logic [4095:0] mval(input int s);
        logic [4095:0] r;
        for (int k = 0; k < 64; k++) r[k*64 +: 64] = m_w[s][k];
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_cnt[s] = 0;
            for (int k = 0; k < 64; k++) m_w[s][k] = '0;
        end
        m_ld  = '0;
        m_err = 1'b0;
    endtask

    task automatic model_word(input int s, input logic [63:0] d, input bit last, input bit clr);
        bit e = 1'b0;
        if (s == 3 || m_ld[s]) e = 1'b1;
        else if (last != (m_cnt[s] == 63)) begin
            e = 1'b1;
            m_cnt[s] = 0;
        end else begin
            m_w[s][m_cnt[s]] = d;
            if (last) begin
                m_ld[s] = 1'b1;
                m_cnt[s] = 0;
            end else m_cnt[s]++;
        end
        m_err = e ? 1'b1 : (clr ? 1'b0 : m_err);
    endtask

    task automatic send(input int s, input logic [63:0] d, input bit last, input bit clr = 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_sel   = 2'(s);
        in_data  = d;
        in_last  = last;
        err_clr  = clr;
        @(posedge clk);
        model_word(s, d, last, clr);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sel   = 2'($urandom);
        in_data  = {$urandom, $urandom};
        in_last  = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic load_rand(input int s);
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 7) == 0) idle();
            send(s, {$urandom, $urandom}, i == 63);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        m_err = 1'b0;
        #1;
        err_clr = 1'b0;
        chk("err_clr", err, 0);
    endtask

    task automatic check_all();
        chk("loaded", loaded, m_ld);
        chk("err", err, m_err);
        chk("message", message, mval(0));
        chk("exponent", exponent, mval(1));
        chk("modulus", modulus, mval(2));
    endtask

    task automatic expect_go();
        chk("go_early", rsa_go, 0);
        @(posedge clk);
        #1;
        chk("go", rsa_go, 1);
        chk("busy_start", busy, 1);
        chk("ready_start", in_ready, 0);
        @(posedge clk);
        #1;
        chk("go_once", rsa_go, 0);
        chk("busy_wait", busy, 1);
    endtask

    task automatic finish_op(input bit keep, input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_sel   = 2'($urandom_range(0, 2));
            in_data  = {$urandom, $urandom};
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_wait", in_ready, 0);
        chk("busy_hold", busy, 1);
        chk("no_early_done", op_done, 0);
        check_all();
        keep_key = keep;
        rsa_done = 1'b1;
        #1;
        chk("op_done", op_done, 1);
        chk("busy_done", busy, 0);
        @(posedge clk);
        m_ld[0] = 1'b0;
        m_cnt[0] = 0;
        if (!keep) begin
            m_ld[2:1] = 2'b00;
            m_cnt[1] = 0;
            m_cnt[2] = 0;
        end
        #1;
        chk("op_done_pulse", op_done, 0);
        chk("ready_load", in_ready, 1);
        check_all();
        @(negedge clk);
        rsa_done = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_go", rsa_go, 0);
        chk("rst_op_done", op_done, 0);
        check_all();
        reset = 1'b0;

        // ordered load with fixed small values
        for (int i = 0; i < 64; i++) send(0, (i == 0) ? 64'd1 : 64'd0, i == 63);
        for (int i = 0; i < 64; i++) send(1, (i == 0) ? 64'd65537 : 64'd0, i == 63);
        for (int i = 0; i < 64; i++) send(2, {$urandom, $urandom} | 64'd1, i == 63);
        check_all();
        expect_go();
        finish_op(1'b1, 500);
        chk("one_done", done_cnt, 1);

        // retained key: message alone restarts
        load_rand(0);
        expect_go();
        finish_op(1'b0, 20);

        // round-robin interleave
        for (int k = 0; k < 64; k++)
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(0, 9) == 0) idle();
                send(s, {$urandom, $urandom}, k == 63);
            end
        check_all();
        expect_go();
        finish_op(1'b0, 10);

        // early last marker on message word 10
        for (int i = 0; i < 10; i++) send(0, {$urandom, $urandom}, 1'b0);
        send(0, {$urandom, $urandom}, 1'b1);
        chk("early_last_err", err, 1);
        chk("early_last_ld", loaded, 3'b000);
        load_rand(0);
        check_all();
        clear_err();

        // illegal select with simultaneous err_clr, then missing last marker
        send(3, {$urandom, $urandom}, 1'b0, 1'b1);
        chk("sel3_err", err, 1);
        clear_err();
        for (int i = 0; i < 64; i++) send(1, {$urandom, $urandom}, 1'b0);
        chk("no_last_err", err, 1);
        chk("no_last_ld", loaded, 3'b001);
        clear_err();
        load_rand(1);
        send(1, {$urandom, $urandom}, 1'b1);
        check_all();
        load_rand(2);
        expect_go();

        // async reset while waiting on rsa4k
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_go", rsa_go, 0);
        chk("arst_ready", in_ready, 1);
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
        chk("go_total", go_cnt, 4);
        chk("done_total", done_cnt, 3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
